// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MIPS32 memory stage and a
// synchronous single-port data RAM with a one-cycle registered read.
// Byte lanes are big-endian: lane 0 is bits 31:24, lane 3 is bits 7:0,
// and mem_we[k] enables lane k.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_misaligned,
    output logic                 resp_range,
    output logic                 mem_en,
    output logic [3:0]           mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wd,
    input  logic [31:0]          mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_next;

    // Request captured at the accepting edge; later input changes are ignored.
    logic                 op_write;
    logic [1:0]           op_size;
    logic                 op_signed;
    logic [ADDR_BITS+1:0] op_addr;
    logic [31:0]          op_wdata;

    logic                 accept;
    logic                 bad_align;
    logic                 bad_range;

    // Byte enables for a store of the given size at byte offset within the word.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] en;
        case (size)
            2'b00:   en = 4'b0001 << offset;
            2'b01:   en = offset[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // Store data replicated across lanes so any enabled lane sees its byte.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    // Pick the addressed lane out of a RAM word and sign- or zero-extend it.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] offset, input logic sext);
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic [31:0]        result;
        case (offset)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = offset[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   result = sext ? 32'(lane_b) : {24'd0, lane_b};
            2'b01:   result = sext ? 32'(lane_h) : {16'd0, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Faults are judged on the live request so an erroring access skips the RAM.
    assign bad_align = (req_size == 2'b11)
                     || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign bad_range = req_addr[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2];

    // mem_addr/mem_wd follow the latched request, so they hold outside ISSUE.
    assign mem_addr = op_addr[ADDR_BITS+1:2];
    assign mem_wd   = lane_data(op_size, op_wdata);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state RAM/response strobes.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bad_align || bad_range) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = op_write ? lane_enables(op_size, op_addr[1:0]) : 4'b0000;
                state_next = op_write ? RESP : WAIT;
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write  <= 1'b0;
            op_size   <= 2'b00;
            op_signed <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= 32'd0;
        end else if (accept) begin
            op_write  <= req_write;
            op_size   <= req_size;
            op_signed <= req_signed;
            op_addr   <= req_addr[ADDR_BITS+1:0];
            op_wdata  <= req_wdata;
        end
    end

    // Response registers: flags set at acceptance, load data captured in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata      <= 32'd0;
            resp_misaligned <= 1'b0;
            resp_range      <= 1'b0;
        end else if (accept) begin
            resp_rdata      <= 32'd0;
            resp_misaligned <= bad_align;
            resp_range      <= bad_range;
        end else if (state == WAIT) begin
            resp_rdata      <= extract_lane(mem_rd, op_size, op_addr[1:0], op_signed);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a byte-addressed reference memory predicts
// every response and every RAM strobe; a bench RAM model serves the DUT.
module tb_mem_access_unit;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          AB   = 11;

    logic          clk, rst;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_ready, resp_misaligned, resp_range;
    logic [31:0]   resp_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AB-1:0] mem_addr;
    logic [31:0]   mem_wd, mem_rd;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.BASE_ADDR(BASE), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_range(resp_range),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (we[k]) r[31-8*k -: 8] = wd[31-8*k -: 8];
        return r;
    endfunction

    // Bench RAM: registered read, per-lane write, lane k = bits 31-8k.
    logic [31:0] ram [0:2047];
    logic        ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int w = 0; w < 2048; w++) ram[w] <= init_word(w);
        end else if (mem_en) begin
            ram[mem_addr] <= merge_bytes(ram[mem_addr], mem_wd, mem_we);
            mem_rd        <= ram[mem_addr];
        end
    end

    // Response consumer.
    bit ready_fixed = 1'b1;
    bit rand_ready  = 1'b0;
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
        end
    end

    // Observations shared with the stimulus for literal checks.
    int            accept_count = 0;
    int            done_count = 0;
    int            seen_lat;
    logic [31:0]   rd_log [$];
    logic [3:0]    last_we;
    logic [31:0]   last_wd;
    logic [AB-1:0] last_ma;
    logic          saw_en, last_mis, last_rng;

    logic [7:0]    ref_mem [0:8191];

    // Reference model and per-cycle compare.
    initial begin : compare
        bit            txn_on, en_exp, rv_exp;
        int            age, n, idx, e_lat;
        logic          e_write, e_mis, e_rng, e_err;
        logic [31:0]   e_rd, e_wd, off, v;
        logic [3:0]    e_we;
        logic [AB-1:0] e_ma;

        txn_on = 0;
        age = 0;
        for (int w = 0; w < 2048; w++) begin
            v = init_word(w);
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[31-8*b -: 8];
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_mem_en", mem_en, 0);
                chk("rst_mem_we", mem_we, 0);
                txn_on = 0;
            end else if (txn_on) begin
                age++;
                en_exp = !e_err && (age == 1);
                chk("mem_en", mem_en, en_exp);
                chk("mem_we", mem_we, (en_exp && e_write) ? e_we : 4'b0000);
                if (en_exp) begin
                    chk("mem_addr", mem_addr, e_ma);
                    if (e_write) chk("mem_wd", mem_wd, e_wd);
                end
                if (mem_en) begin
                    saw_en  = 1;
                    last_we = mem_we;
                    last_wd = mem_wd;
                    last_ma = mem_addr;
                end
                chk("req_ready_busy", req_ready, 0);
                rv_exp = (age >= e_lat);
                chk("resp_valid", resp_valid, rv_exp);
                if (resp_valid && seen_lat == 0) seen_lat = age;
                if (rv_exp) begin
                    chk("resp_rdata", resp_rdata, e_rd);
                    chk("resp_misaligned", resp_misaligned, e_mis);
                    chk("resp_range", resp_range, e_rng);
                    if (resp_ready) begin
                        rd_log.push_back(resp_rdata);
                        last_mis = resp_misaligned;
                        last_rng = resp_range;
                        txn_on = 0;
                        done_count++;
                    end
                end
            end else begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_resp_valid", resp_valid, 0);
                chk("idle_mem_en", mem_en, 0);
                chk("idle_mem_we", mem_we, 0);
                if (req_valid) begin
                    // Request is taken at the coming edge: predict its outcome.
                    e_write = req_write;
                    off     = req_addr - BASE;
                    e_rng   = (off >= 32'd8192);
                    e_mis   = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0])
                              || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
                    e_err   = e_rng || e_mis;
                    e_lat   = e_err ? 1 : (req_write ? 2 : 3);
                    n       = 1 << req_size;
                    e_rd    = 32'd0;
                    e_we    = 4'b0000;
                    e_wd    = 32'd0;
                    e_ma    = '0;
                    if (!e_err) begin
                        idx  = int'(off[12:0]);
                        e_ma = AB'(idx / 4);
                        if (n == 1)      e_wd = 32'(req_wdata[7:0]) * 32'h01010101;
                        else if (n == 2) e_wd = 32'(req_wdata[15:0]) * 32'h00010001;
                        else             e_wd = req_wdata;
                        for (int i = 0; i < n; i++) begin
                            if (req_write) begin
                                e_we[(idx % 4) + i] = 1'b1;
                                ref_mem[idx+i] = 8'(req_wdata >> (8 * (n - 1 - i)));
                            end else begin
                                e_rd = (e_rd << 8) | 32'(ref_mem[idx+i]);
                            end
                        end
                        if (!req_write && req_signed && n < 4 && e_rd[8*n-1])
                            e_rd = e_rd | ~((32'd1 << (8 * n)) - 32'd1);
                    end
                    txn_on   = 1;
                    age      = 0;
                    saw_en   = 0;
                    seen_lat = 0;
                    accept_count++;
                end
            end
        end
    end

    task automatic send_req(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] d);
        int c0 = accept_count;
        bit ok = 0;
        @(posedge clk);
        #2;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (accept_count != c0) begin
                ok = 1;
                break;
            end
        end
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: accepts=%0d required=%0d", accept_count, c0 + 1);
        end
    endtask

    task automatic wait_done(input int target);
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (done_count >= target) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done=%0d required=%0d", done_count, target);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        int d0 = done_count;
        send_req(w, sz, sg, a, d);
        wait_done(d0 + 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_misaligned"}, resp_misaligned, 0);
        chk({tag, "_resp_range"}, resp_range, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
    endtask

    // Abandon a word load by asynchronous reset after 'extra' edges past ISSUE.
    task automatic reset_during_load(input int extra, input string tag);
        ready_fixed = 0;
        send_req(1'b0, 2'd2, 1'b0, BASE, 32'd0);
        repeat (extra) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        ready_fixed = 1;
    endtask

    initial begin : stimulus
        int          d0, r;
        logic [1:0]  sz;
        logic [31:0] a, o;

        rst = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0; ram_init = 1'b0;

        do_req(1'b1, 2'd2, 1'b0, BASE, 32'h11223344);
        chk("sw_we", last_we, 4'b1111);
        chk("sw_addr", last_ma, 0);
        chk("sw_wd", last_wd, 32'h11223344);
        chk("sw_latency", seen_lat, 2);
        chk("sw_flags", {last_mis, last_rng}, 0);

        do_req(1'b1, 2'd0, 1'b0, BASE + 32'd1, 32'h000000A5);
        chk("sb_we", last_we, 4'b0010);
        chk("sb_wd", last_wd, 32'hA5A5A5A5);

        do_req(1'b0, 2'd2, 1'b0, BASE, 32'd0);
        chk("lw_data", rd_log[$], 32'h11A53344);
        chk("lw_latency", seen_lat, 3);
        do_req(1'b0, 2'd0, 1'b1, BASE + 32'd1, 32'd0);
        chk("lb_data", rd_log[$], 32'hFFFFFFA5);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'd1, 32'd0);
        chk("lbu_data", rd_log[$], 32'h000000A5);
        do_req(1'b0, 2'd1, 1'b1, BASE + 32'd2, 32'd0);
        chk("lh2_data", rd_log[$], 32'h00003344);
        do_req(1'b0, 2'd1, 1'b1, BASE, 32'd0);
        chk("lh0_data", rd_log[$], 32'h000011A5);

        do_req(1'b0, 2'd2, 1'b0, BASE + 32'd2, 32'd0);
        chk("lw_mis_flag", last_mis, 1);
        chk("lw_mis_data", rd_log[$], 0);
        chk("lw_mis_no_ram", saw_en, 0);
        chk("lw_mis_latency", seen_lat, 1);
        do_req(1'b0, 2'd3, 1'b0, BASE, 32'd0);
        chk("size11_flag", last_mis, 1);
        do_req(1'b1, 2'd2, 1'b0, 32'h10012000, 32'hDEADBEEF);
        chk("sw_range_flag", last_rng, 1);
        chk("sw_range_mis", last_mis, 0);
        chk("sw_range_no_ram", saw_en, 0);
        do_req(1'b0, 2'd2, 1'b0, BASE, 32'd0);
        chk("ram_unchanged", rd_log[$], 32'h11A53344);

        // Backpressure: response held while a second request waits.
        ready_fixed = 0;
        d0 = done_count;
        send_req(1'b0, 2'd2, 1'b0, BASE, 32'd0);
        fork
            send_req(1'b0, 2'd0, 1'b1, BASE + 32'd1, 32'd0);
            begin
                repeat (8) @(posedge clk);
                ready_fixed = 1;
            end
        join
        wait_done(d0 + 2);
        chk("bp_first", rd_log[rd_log.size()-2], 32'h11A53344);
        chk("bp_second", rd_log[$], 32'hFFFFFFA5);

        reset_during_load(0, "rst_issue");
        reset_during_load(1, "rst_wait");
        reset_during_load(2, "rst_resp");
        do_req(1'b0, 2'd2, 1'b0, BASE, 32'd0);
        chk("post_reset_lw", rd_log[$], 32'h11A53344);

        // Randomized traffic with random consumer backpressure.
        rand_ready = 1;
        for (int t = 0; t < 250; t++) begin
            r  = $urandom_range(0, 9);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            o  = $urandom_range(0, 8191);
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) o[0] = 1'b0;
                if (sz == 2'd2) o[1:0] = 2'b00;
            end
            if (r == 0)      a = $urandom;
            else if (r == 1) a = BASE + 32'd8192 + o;
            else if (r == 2) a = BASE - o - 32'd1;
            else             a = BASE + o;
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        rand_ready = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the MIPS32 core's memory stage and the 2048-word data RAM.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Checks alignment and address range, then drives the RAM's enable, per-byte write enables, word address and write data.
- For loads, waits out the RAM's one-cycle registered read, then extracts and sign- or zero-extends the addressed lane.
- Returns the result over a valid/ready response handshake.

Parameters:
- BASE_ADDR, 32'h10010000, byte address of RAM word 0; bits [ADDR_BITS+1:0] must be zero.
- ADDR_BITS, 11, RAM word-address width (2048 words).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; 1 only in IDLE with rst low.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_misaligned  out  1  alignment fault or illegal size.
- resp_range  out  1  address outside the RAM window.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM per-byte write enables.
- mem_addr  out  ADDR_BITS  RAM word address.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM read data; valid the cycle after mem_en.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - resp_valid, resp_rdata, resp_misaligned, resp_range, mem_en, mem_we all 0.
  - Latched request registers cleared.
  - req_ready forced 0 while rst is high.
- Reset mid-operation: any in-flight access is abandoned. A store is either fully written (RAM edge already taken) or not written at all.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch write, size, signed, addr and wdata.
  - Compute errors:
    - misaligned = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
    - range = addr[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2].
  - Any error: next state RESP with the flag(s) set and resp_rdata=0. Both flags may be set together. No RAM access occurs.
  - Otherwise: next state ISSUE.
- ISSUE (exactly one cycle):
  - mem_en=1 and mem_addr=addr[ADDR_BITS+1:2].
  - Big-endian lanes, byte offset o=addr[1:0]:
    - Byte: mem_we bit o set; offset 0 maps to mem_we[0] (bits 31:24), offset 3 to mem_we[3] (bits 7:0).
    - Half: o=0 gives 4'b0011, o=2 gives 4'b1100.
    - Word: 4'b1111.
    - Loads: mem_we=0.
  - mem_wd: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
  - Next state: store goes to RESP, load goes to WAIT.
- WAIT (loads only):
  - mem_en=0, mem_we=0.
  - mem_rd is valid and stable.
  - Select lane: byte = mem_rd[31-8o -: 8]; half = mem_rd[31:16] for o=0, mem_rd[15:0] for o=2.
  - Extend per signed; register into resp_rdata.
  - Next state RESP.
- RESP:
  - resp_valid=1; outputs held stable until resp_ready=1.
  - On resp_ready, that edge clears resp_valid and returns to IDLE.
  - req_ready=0, so a new request is accepted no earlier than the following cycle.
- mem_en and mem_we are 0 in every state except ISSUE. mem_addr and mem_wd are don't-care outside ISSUE and hold their last value.
- Latency with resp_ready held at 1, counting from the accepting edge to resp_valid high:
  - store: 2 cycles.
  - load: 3 cycles.
  - error: 1 cycle.
- Throughput: one request per 3 (store) or 4 (load) cycles.
- Request inputs are ignored outside IDLE. Changing them after acceptance has no effect.

Test Plan:
- Reset, then sw 0x11223344 @0x10010000 → one ISSUE cycle with mem_we=1111, mem_addr=0, mem_wd=0x11223344; resp_valid two cycles after accept with both error flags 0.
- sb 0xA5 @0x10010001 → mem_we=0010, mem_wd=0xA5A5A5A5. A following lw @0x10010000 → resp_rdata=0x11A53344 three cycles after accept.
- lb signed @0x10010001 → 0xFFFFFFA5. lbu → 0x000000A5. lh signed @0x10010002 → 0x00003344. lh signed @0x10010000 → 0x000011A5.
- lw @0x10010002 → resp_misaligned=1, resp_rdata=0, mem_en never asserted, resp_valid one cycle after accept. req_size=11 → resp_misaligned=1. sw @0x10012000 → resp_range=1 and RAM unchanged.
- Load with resp_ready=0 for 5 cycles → resp_valid and resp_rdata held constant, req_ready=0, a pending req_valid is not accepted; it is accepted the cycle after resp_ready handshakes.
- Assert rst asynchronously during WAIT → all outputs 0 immediately and req_ready=0. After release, state is IDLE; a fresh lw returns the correct data.
